// File: rtl/scanline_pkg.sv
// Shared types and constants for the scanline dimming sequencer.
// The cfg record is sized for the default geometry (8 steps, 3-bit repeat).
package scanline_pkg;

    localparam int SL_MAX_LEN = 8;
    localparam int SL_REP_W   = 3;
    localparam int LEVEL_W    = 2;

    localparam logic [LEVEL_W-1:0] LVL_NONE = 2'd0;
    localparam logic [LEVEL_W-1:0] LVL_25   = 2'd1;
    localparam logic [LEVEL_W-1:0] LVL_50   = 2'd2;
    localparam logic [LEVEL_W-1:0] LVL_75   = 2'd3;

    typedef struct packed {
        logic [2*SL_MAX_LEN-1:0] pattern;
        logic [3:0]              len;
        logic [SL_REP_W-1:0]     rep;
        logic [2:0]              phase;
        logic                    interlace;
        logic                    enable;
    } scanline_cfg_t;

    localparam scanline_cfg_t CFG_ACTIVE_RST = '{
        pattern:   '0,
        len:       4'd1,
        rep:       '0,
        phase:     3'd0,
        interlace: 1'b0,
        enable:    1'b0
    };

endpackage

// File: rtl/scanline_edge_det.sv
// Registered falling-edge detector: the strobe is high in the cycle
// whose rising clock edge sees the input drop.
module scanline_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic fall
);

    logic sig_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    assign fall = sig_d & ~sig;

endmodule

// File: rtl/scanline_seq.sv
// Scanline dim sequencer: counts lines from hs/vs and emits a per-line dim level
// from a double-buffered pattern that only switches at frame start.
module scanline_seq
    import scanline_pkg::*;
#(
    parameter int MAX_LEN = SL_MAX_LEN,
    parameter int REP_W   = SL_REP_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hs,
    input  logic                 vs,
    input  logic                 cfg_we,
    input  logic [2*MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]           cfg_len,
    input  logic [REP_W-1:0]     cfg_rep,
    input  logic [2:0]           cfg_phase,
    input  logic                 cfg_interlace,
    input  logic                 cfg_enable,
    output logic                 cfg_pending,
    output logic [LEVEL_W-1:0]   level,
    output logic                 field,
    output logic [2:0]           step_idx
);

    logic hs_fall;
    logic vs_fall;

    scanline_edge_det u_hs_det (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (hs),
        .fall    (hs_fall)
    );

    scanline_edge_det u_vs_det (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (vs),
        .fall    (vs_fall)
    );

    scanline_cfg_t staging;
    scanline_cfg_t active;
    logic [REP_W-1:0] rep_cnt;

    scanline_cfg_t        staging_nxt;
    scanline_cfg_t        active_nxt;
    logic                 pending_nxt;
    logic                 field_nxt;
    logic [REP_W-1:0]     rep_cnt_nxt;
    logic [2:0]           step_nxt;
    logic [LEVEL_W-1:0]   level_nxt;

    // Clamped length and phase are stored, so downstream logic never sees len 0.
    function automatic scanline_cfg_t apply_cfg(input scanline_cfg_t s);
        scanline_cfg_t a;
        logic [3:0]    l;
        a = s;
        if (s.len == 4'd0) begin
            l = 4'd1;
        end else if (s.len > 4'(MAX_LEN)) begin
            l = 4'(MAX_LEN);
        end else begin
            l = s.len;
        end
        a.len   = l;
        a.phase = 3'({1'b0, s.phase} % l);
        return a;
    endfunction

    always_comb begin
        staging_nxt = staging;
        active_nxt  = active;
        pending_nxt = cfg_pending;
        field_nxt   = field;
        rep_cnt_nxt = rep_cnt;
        step_nxt    = step_idx;

        if (vs_fall && cfg_pending) begin
            active_nxt  = apply_cfg(staging);
            pending_nxt = 1'b0;
        end
        if (cfg_we) begin
            staging_nxt = '{
                pattern:   cfg_pattern,
                len:       cfg_len,
                rep:       cfg_rep,
                phase:     cfg_phase,
                interlace: cfg_interlace,
                enable:    cfg_enable
            };
            pending_nxt = 1'b1;
        end

        // Frame start wins over a coincident line boundary.
        if (vs_fall) begin
            field_nxt   = active_nxt.interlace ? ~field : 1'b0;
            rep_cnt_nxt = '0;
            step_nxt    = field_nxt ? active_nxt.phase : 3'd0;
        end else if (hs_fall) begin
            if (rep_cnt == active.rep) begin
                rep_cnt_nxt = '0;
                step_nxt    = ({1'b0, step_idx} == active.len - 4'd1) ? 3'd0 : step_idx + 3'd1;
            end else begin
                rep_cnt_nxt = rep_cnt + 1'b1;
            end
        end

        level_nxt = active_nxt.enable ? active_nxt.pattern[{step_nxt, 1'b0} +: LEVEL_W] : LVL_NONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            staging     <= '0;
            active      <= CFG_ACTIVE_RST;
            cfg_pending <= 1'b0;
            field       <= 1'b0;
            rep_cnt     <= '0;
            step_idx    <= 3'd0;
            level       <= LVL_NONE;
        end else begin
            staging     <= staging_nxt;
            active      <= active_nxt;
            cfg_pending <= pending_nxt;
            field       <= field_nxt;
            rep_cnt     <= rep_cnt_nxt;
            step_idx    <= step_nxt;
            level       <= level_nxt;
        end
    end

    a_step_in_range: assert property (@(posedge clk) disable iff (!reset_n)
        {1'b0, step_idx} < active.len);

endmodule

// File: tb/tb_scanline_seq.sv
// Directed bench for scanline_seq: drives hs/vs/cfg on the falling clock edge
// and compares outputs against hand-computed sequences.
module tb_scanline_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hs;
    logic        vs;
    logic        cfg_we;
    logic [15:0] cfg_pattern;
    logic [3:0]  cfg_len;
    logic [2:0]  cfg_rep;
    logic [2:0]  cfg_phase;
    logic        cfg_interlace;
    logic        cfg_enable;
    logic        cfg_pending;
    logic [1:0]  level;
    logic        field;
    logic [2:0]  step_idx;

    int total = 0;
    int bad   = 0;

    scanline_seq #(.MAX_LEN(8), .REP_W(3)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .hs            (hs),
        .vs            (vs),
        .cfg_we        (cfg_we),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_rep       (cfg_rep),
        .cfg_phase     (cfg_phase),
        .cfg_interlace (cfg_interlace),
        .cfg_enable    (cfg_enable),
        .cfg_pending   (cfg_pending),
        .level         (level),
        .field         (field),
        .step_idx      (step_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [15:0] pat, input logic [3:0] len, input logic [2:0] rep,
                           input logic [2:0] ph, input logic il, input logic en);
        cfg_pattern   = pat;
        cfg_len       = len;
        cfg_rep       = rep;
        cfg_phase     = ph;
        cfg_interlace = il;
        cfg_enable    = en;
    endtask

    task automatic write_cfg(input logic [15:0] pat, input logic [3:0] len, input logic [2:0] rep,
                             input logic [2:0] ph, input logic il, input logic en);
        set_cfg(pat, len, rep, ph, il, en);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic line();
        hs = 1'b1;
        tick();
        hs = 1'b0;
        tick();
    endtask

    task automatic frame();
        vs = 1'b1;
        tick();
        vs = 1'b0;
        tick();
    endtask

    initial begin
        logic [1:0] exp_seq2 [0:3];
        logic [1:0] exp_seq3 [0:5];
        exp_seq2 = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_seq3 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};

        reset_n = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
        cfg_we = 1'b0;
        set_cfg(16'h0, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_field", 32'(field), 32'd0);
        chk("rst_step", 32'(step_idx), 32'd0);
        chk("rst_pending", 32'(cfg_pending), 32'd0);

        // 4-step ramp pattern, one line per step
        write_cfg(16'h00E4, 4'd4, 3'd0, 3'd0, 1'b0, 1'b1);
        chk("ramp_pending_set", 32'(cfg_pending), 32'd1);
        frame();
        chk("ramp_pending_clr", 32'(cfg_pending), 32'd0);
        chk("ramp_level0", 32'(level), 32'd0);
        for (int i = 0; i < 4; i++) begin
            line();
            chk($sformatf("ramp_level_l%0d", i + 1), 32'(level), 32'(exp_seq2[i]));
        end

        // repeat 3 lines per step, 2 steps
        write_cfg(16'h0004, 4'd2, 3'd2, 3'd0, 1'b0, 1'b1);
        frame();
        chk("rep_level0", 32'(level), 32'd0);
        for (int i = 0; i < 6; i++) begin
            line();
            chk($sformatf("rep_level_l%0d", i + 1), 32'(level), 32'(exp_seq3[i]));
        end

        // interlace: field toggles, odd field starts at phase
        write_cfg(16'h0009, 4'd2, 3'd0, 3'd1, 1'b1, 1'b1);
        frame();
        chk("il_f1_field", 32'(field), 32'd1);
        chk("il_f1_step", 32'(step_idx), 32'd1);
        chk("il_f1_level", 32'(level), 32'd2);
        line();
        chk("il_f1_wrap_step", 32'(step_idx), 32'd0);
        frame();
        chk("il_f2_field", 32'(field), 32'd0);
        chk("il_f2_step", 32'(step_idx), 32'd0);
        chk("il_f2_level", 32'(level), 32'd1);
        frame();
        chk("il_f3_field", 32'(field), 32'd1);
        chk("il_f3_step", 32'(step_idx), 32'd1);

        // mid-frame write stays staged until frame start
        write_cfg(16'h000F, 4'd2, 3'd0, 3'd0, 1'b0, 1'b1);
        chk("mid_pending", 32'(cfg_pending), 32'd1);
        line();
        chk("mid_old_level", 32'(level), 32'd1);
        frame();
        chk("mid_new_level", 32'(level), 32'd3);
        chk("mid_new_field", 32'(field), 32'd0);
        chk("mid_pending_clr", 32'(cfg_pending), 32'd0);

        // write coinciding with frame start: older staging applies, new one stays pending
        write_cfg(16'h0002, 4'd1, 3'd0, 3'd0, 1'b0, 1'b1);
        vs = 1'b1;
        tick();
        vs = 1'b0;
        set_cfg(16'h0001, 4'd1, 3'd0, 3'd0, 1'b0, 1'b1);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("vswe_level", 32'(level), 32'd2);
        chk("vswe_pending", 32'(cfg_pending), 32'd1);
        frame();
        chk("vswe_next_level", 32'(level), 32'd1);
        chk("vswe_next_pending", 32'(cfg_pending), 32'd0);

        // coincident hs/vs fall: hs ignored, repeat counter cleared
        write_cfg(16'h00E4, 4'd4, 3'd1, 3'd0, 1'b0, 1'b1);
        frame();
        line();
        chk("sim_pre_step", 32'(step_idx), 32'd0);
        hs = 1'b1;
        vs = 1'b1;
        tick();
        hs = 1'b0;
        vs = 1'b0;
        tick();
        chk("sim_step", 32'(step_idx), 32'd0);
        line();
        chk("sim_rep_cleared", 32'(step_idx), 32'd0);
        line();
        chk("sim_step_adv", 32'(step_idx), 32'd1);
        chk("sim_level_adv", 32'(level), 32'd1);

        // len 0 clamps to a single step
        write_cfg(16'h00E5, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1);
        frame();
        line();
        line();
        chk("len0_step", 32'(step_idx), 32'd0);
        chk("len0_level", 32'(level), 32'd1);

        // len 12 clamps to 8
        write_cfg(16'hE4E4, 4'd12, 3'd0, 3'd0, 1'b0, 1'b1);
        frame();
        repeat (7) line();
        chk("len12_step7", 32'(step_idx), 32'd7);
        chk("len12_level7", 32'(level), 32'd3);
        line();
        chk("len12_wrap", 32'(step_idx), 32'd0);

        // phase larger than len wraps modulo len
        write_cfg(16'h00E4, 4'd3, 3'd0, 3'd5, 1'b1, 1'b1);
        frame();
        chk("phmod_field", 32'(field), 32'd1);
        chk("phmod_step", 32'(step_idx), 32'd2);
        chk("phmod_level", 32'(level), 32'd2);

        // disabled config forces level 0
        write_cfg(16'hFFFF, 4'd2, 3'd0, 3'd0, 1'b0, 1'b0);
        frame();
        line();
        chk("dis_level", 32'(level), 32'd0);

        // asynchronous reset in the middle of a line
        write_cfg(16'hFFFF, 4'd4, 3'd0, 3'd3, 1'b1, 1'b1);
        frame();
        chk("pre_rst_level", 32'(level), 32'd3);
        hs = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_field", 32'(field), 32'd0);
        chk("arst_step", 32'(step_idx), 32'd0);
        chk("arst_pending", 32'(cfg_pending), 32'd0);
        tick();
        hs = 1'b0;
        reset_n = 1'b1;
        tick();
        line();
        frame();
        chk("post_rst_level", 32'(level), 32'd0);
        chk("post_rst_pending", 32'(cfg_pending), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
